// File: rtl/retry_start_if.sv
// Handshake bundle for retry_start: new-input, pipeline-output and retry-request channels.
interface retry_start_if #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 1
);
  DataType             data_i;
  logic                valid_i;
  logic                ready_o;
  DataType             data_o;
  logic [IDSize-1:0]   id_o;
  logic                valid_o;
  logic                ready_i;
  logic [IDSize-1:0]   retry_id_i;
  logic                retry_valid_i;
  logic                retry_ready_o;
  logic                error_o;

  modport slave (
    input  data_i, valid_i, ready_i, retry_id_i, retry_valid_i,
    output ready_o, data_o, id_o, valid_o, retry_ready_o, error_o
  );

  modport master (
    output data_i, valid_i, ready_i, retry_id_i, retry_valid_i,
    input  ready_o, data_o, id_o, valid_o, retry_ready_o, error_o
  );
endinterface

// File: rtl/retry_start.sv
// Entry stage of the time-redundancy retry loop: ID assignment, replay buffer, retry priority.
// Optional per-ID retry limit enabled by defining RETRY_START_MAX_RETRY_EN.
module retry_start #(
  parameter type         DataType   = logic,
  parameter int unsigned IDSize     = 1,
  parameter int unsigned MaxRetries = 3
) (
  input logic           clk_i,
  input logic           rst_i,
  retry_start_if.slave  bus
);
  localparam int unsigned Depth = 2**IDSize;

  logic              load;
  logic              take_retry;
  logic              take_new;
  logic              drop;
  logic              valid_d;
  DataType           data_d;
  logic [IDSize-1:0] id_d;
  logic [IDSize-1:0] id_q;
  DataType           buf_q [Depth];

  always_comb begin
    load              = ~bus.valid_o | bus.ready_i;
    bus.retry_ready_o = load;
    bus.ready_o       = load & ~bus.retry_valid_i;
    take_retry        = load & bus.retry_valid_i & ~drop;
    take_new          = load & ~bus.retry_valid_i & bus.valid_i;
    valid_d           = take_retry | take_new;
    data_d            = take_retry ? buf_q[bus.retry_id_i] : bus.data_i;
    id_d              = take_retry ? bus.retry_id_i : id_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      bus.id_o    <= '0;
      id_q        <= '0;
    end else begin
      if (load) begin
        bus.valid_o <= valid_d;
        if (valid_d) begin
          bus.data_o <= data_d;
          bus.id_o   <= id_d;
        end
      end
      if (take_new) id_q <= id_q + 1'b1;
    end
  end

  // Replay storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (take_new) buf_q[id_q] <= bus.data_i;
  end

`ifdef RETRY_START_MAX_RETRY_EN
  localparam int unsigned CntW = $clog2(MaxRetries + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRetries);

  logic [CntW-1:0] cnt_q [Depth];

  assign drop = bus.retry_valid_i & (cnt_q[bus.retry_id_i] == MaxCnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) cnt_q[i] <= '0;
      bus.error_o <= 1'b0;
    end else begin
      bus.error_o <= load & drop;
      if (take_retry)
        cnt_q[bus.retry_id_i] <= cnt_q[bus.retry_id_i] + 1'b1;
      else if (take_new)
        cnt_q[id_q] <= '0;
    end
  end
`else
  assign drop        = 1'b0;
  assign bus.error_o = 1'b0;
`endif

endmodule
